// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute/decode-stage signals exchanged with the mult/div unit.
// The pipeline side is master; the unit itself is slave.
interface muldiv_unit_if;
    logic        StartE;
    logic [1:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        HiWriteE;
    logic        LoWriteE;
    logic        CancelE;
    logic        HiLoReadD;
    logic        MdStartD;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        BusyE;
    logic        DoneE;
    logic        MdStall;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, HiWriteE, LoWriteE,
        output CancelE, HiLoReadD, MdStartD,
        input  Hi, Lo, BusyE, DoneE, MdStall
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, HiWriteE, LoWriteE,
        input  CancelE, HiLoReadD, MdStartD,
        output Hi, Lo, BusyE, DoneE, MdStall
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 mult/multu/div/divu owning HI and LO.
// Magnitudes are processed for 32 CALC cycles, then signs are fixed in SIGN.
module muldiv_unit (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_m;
    logic [31:0] r_srca;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_done;

    logic        w_busy;
    logic        w_start;
    logic        w_sgn;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_busy  = (r_state != IDLE);
    assign w_start = (r_state == IDLE) && bus.StartE && !bus.CancelE;
    assign w_sgn   = ~bus.OpE[0];
    assign w_neg_a = w_sgn & bus.SrcAE[31];
    assign w_neg_b = w_sgn & bus.SrcBE[31];
    assign w_abs_a = w_neg_a ? (~bus.SrcAE + 32'd1) : bus.SrcAE;
    assign w_abs_b = w_neg_b ? (~bus.SrcBE + 32'd1) : bus.SrcBE;

    // r_a: product high / partial remainder; r_b: multiplier / quotient.
    assign w_sum   = {1'b0, r_a} + {1'b0, (r_b[0] ? r_m : 32'd0)};
    assign w_shift = {r_a, r_b[31]};
    assign w_diff  = w_shift - {1'b0, r_m};

    assign w_prod  = r_neg_q ? (~{r_a, r_b} + 64'd1) : {r_a, r_b};
    assign w_quo   = r_neg_q ? (~r_b + 32'd1) : r_b;
    assign w_rem   = r_neg_r ? (~r_a + 32'd1) : r_a;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start)
                    w_next = CALC;
            end
            CALC: begin
                if (bus.CancelE)
                    w_next = IDLE;
                else if (r_cnt == 5'd31)
                    w_next = SIGN;
            end
            SIGN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_m     <= 32'd0;
            r_srca  <= 32'd0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= bus.OpE[1] ? w_abs_a : w_abs_b;
            r_m     <= bus.OpE[1] ? w_abs_b : w_abs_a;
            r_srca  <= bus.SrcAE;
            r_div   <= bus.OpE[1];
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 5'd1;
            if (!r_div) begin
                r_a <= w_sum[32:1];
                r_b <= {w_sum[0], r_b[31:1]};
            end else begin
                r_a <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
                r_b <= {r_b[30:0], ~w_diff[32]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.HiWriteE)
                    r_hi <= bus.SrcAE;
                if (bus.LoWriteE)
                    r_lo <= bus.SrcAE;
            end else if (r_state == SIGN && !bus.CancelE) begin
                r_done <= 1'b1;
                if (!r_div) begin
                    {r_hi, r_lo} <= w_prod;
                end else if (r_m == 32'd0) begin
                    r_hi <= r_srca;
                    r_lo <= 32'hFFFF_FFFF;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign bus.Hi      = r_hi;
    assign bus.Lo      = r_lo;
    assign bus.BusyE   = w_busy;
    assign bus.DoneE   = r_done;
    assign bus.MdStall = w_busy & (bus.HiLoReadD | bus.MdStartD);

    // The hazard unit must hold back a new mult/div while one is in flight.
    a_no_start_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.StartE && w_busy)
    ) else $error("muldiv_unit: StartE while BusyE");
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue of expected HI/LO.
// A negedge monitor pops an entry on every DoneE pulse.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;

    muldiv_unit_if bus ();

    muldiv_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.DoneE === 1'b1) begin
            exp_t e;
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got DoneE=1 expected none");
            end else begin
                e = exp_q.pop_front();
                check("sb_hi", bus.Hi, e.hi);
                check("sb_lo", bus.Lo, e.lo);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit hw,
                          input int rd_at);
        int cyc;
        int d0;
        int bad;
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        exp_q.push_back(e);
        d0 = n_done;
        bus.OpE      = op;
        bus.SrcAE    = a;
        bus.SrcBE    = b;
        bus.StartE   = 1'b1;
        bus.HiWriteE = hw;
        @(posedge clk);
        #1;
        bus.StartE   = 1'b0;
        bus.HiWriteE = 1'b0;
        if (hw)
            check("mthi_with_start", bus.Hi, a);
        cyc = 0;
        bad = 0;
        @(negedge clk);
        while (bus.BusyE === 1'b1 && cyc < 100) begin
            cyc++;
            if (rd_at >= 0 && cyc == rd_at)
                bus.HiLoReadD = 1'b1;
            else if (rd_at >= 0 && cyc > rd_at && bus.MdStall !== 1'b1)
                bad++;
            @(negedge clk);
        end
        check("busy_cycles", cyc, 33);
        if (rd_at >= 0) begin
            check("stall_while_busy", bad, 0);
            check("stall_in_done_cycle", bus.MdStall, 0);
            bus.HiLoReadD = 1'b0;
        end
        @(posedge clk);
        #1;
        check("done_count", n_done, d0 + 1);
        check("done_one_cycle", bus.DoneE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n         = 1'b0;
        bus.StartE    = 1'b0;
        bus.OpE       = 2'b00;
        bus.SrcAE     = 32'd0;
        bus.SrcBE     = 32'd0;
        bus.HiWriteE  = 1'b0;
        bus.LoWriteE  = 1'b0;
        bus.CancelE   = 1'b0;
        bus.HiLoReadD = 1'b0;
        bus.MdStartD  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", bus.Hi, 0);
        check("rst_lo", bus.Lo, 0);
        check("rst_busy", bus.BusyE, 0);
        check("rst_done", bus.DoneE, 0);
        check("rst_stall", bus.MdStall, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, -1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0, -1);
        run_op(2'b01, 32'h1234_5678, 32'h100, 32'h12, 32'h3456_7800, 0, -1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, -1);
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, -1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, -1);
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0, -1);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, -1);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 0, -1);
        run_op(2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 0, 3);

        bus.HiLoReadD = 1'b1;
        bus.MdStartD  = 1'b1;
        #1;
        check("stall_idle", bus.MdStall, 0);
        bus.HiLoReadD = 1'b0;
        bus.MdStartD  = 1'b0;

        @(negedge clk);
        bus.SrcAE    = 32'hAAAA_5555;
        bus.HiWriteE = 1'b1;
        @(posedge clk);
        #1;
        bus.HiWriteE = 1'b0;
        bus.SrcAE    = 32'h1234_5678;
        bus.LoWriteE = 1'b1;
        @(posedge clk);
        #1;
        bus.LoWriteE = 1'b0;
        check("mthi", bus.Hi, 32'hAAAA_5555);
        check("mtlo", bus.Lo, 32'h1234_5678);

        @(negedge clk);
        d0         = n_done;
        bus.OpE    = 2'b00;
        bus.SrcAE  = 32'd7;
        bus.SrcBE  = 32'd9;
        bus.StartE = 1'b1;
        @(posedge clk);
        #1;
        bus.StartE = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                bus.SrcAE    = 32'hDEAD_BEEF;
                bus.HiWriteE = 1'b1;
                bus.LoWriteE = 1'b1;
            end
            if (i == 6) begin
                bus.HiWriteE = 1'b0;
                bus.LoWriteE = 1'b0;
            end
            if (i == 10)
                bus.CancelE = 1'b1;
        end
        @(negedge clk);
        bus.CancelE = 1'b0;
        check("cancel_busy", bus.BusyE, 0);
        repeat (40) @(negedge clk);
        check("cancel_hi", bus.Hi, 32'hAAAA_5555);
        check("cancel_lo", bus.Lo, 32'h1234_5678);
        check("cancel_no_done", n_done, d0);

        bus.StartE  = 1'b1;
        bus.CancelE = 1'b1;
        @(posedge clk);
        #1;
        bus.StartE  = 1'b0;
        bus.CancelE = 1'b0;
        @(negedge clk);
        check("cancel_start_busy", bus.BusyE, 0);

        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1, -1);

        @(negedge clk);
        bus.OpE    = 2'b11;
        bus.SrcAE  = 32'd100;
        bus.SrcBE  = 32'd7;
        bus.StartE = 1'b1;
        @(posedge clk);
        #1;
        bus.StartE    = 1'b0;
        bus.HiLoReadD = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hi", bus.Hi, 0);
        check("arst_lo", bus.Lo, 0);
        check("arst_busy", bus.BusyE, 0);
        check("arst_done", bus.DoneE, 0);
        check("arst_stall", bus.MdStall, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.HiLoReadD = 1'b0;
        run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 0, -1);

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
